// File: rtl/fp_pkg.sv
// Shared constants and width helpers for the custom unsigned float datapath.
// Used by the multiplier and by the normalise/round stage it shares with the adder.
package fp_pkg;

  localparam int ROUND_TRUNC = 0;
  localparam int ROUND_RNE   = 1;

  function automatic int expw(input int n, input int point);
    return n - point;
  endfunction

  function automatic int prodw(input int p1, input int p2);
    return p1 + p2 + 2;
  endfunction

  // Signed exponent path: widest field plus room for two unbiasings,
  // the normalise and round carries and the output bias.
  function automatic int sumw(input int e1, input int e2, input int eo);
    int m;
    m = (e1 > e2) ? e1 : e2;
    if (eo > m) m = eo;
    return m + 4;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Combinational normalise, round-to-nearest-even (or truncate), saturate and flush.
// Takes a raw mantissa product in [1,4) with its unbiased signed exponent.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int PW        = 18,
  parameter int SW        = 8,
  parameter int N         = 12,
  parameter int OUT_POINT = 8,
  parameter int OUT_BIAS  = 7,
  parameter int ROUND     = ROUND_RNE
) (
  input  logic [PW-1:0]        prod,
  input  logic signed [SW-1:0] exp_sum,
  input  logic                 zero,
  output logic [N-1:0]         result,
  output logic                 of,
  output logic                 uf
);

  localparam int FW  = PW - 1;
  localparam int GW  = FW + OUT_POINT + 2;
  localparam int EWO = expw(N, OUT_POINT);
  localparam int MW  = OUT_POINT + 1;
  localparam logic signed [SW-1:0] EB_MAX = SW'((1 << EWO) - 1);

  logic [FW-1:0]        frac;
  logic [GW-1:0]        grid;
  logic [OUT_POINT-1:0] mant;
  logic [OUT_POINT:0]   mant_inc;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic signed [SW-1:0] exp_n;
  logic signed [SW-1:0] exp_r;
  logic signed [SW-1:0] eb;

  always_comb begin
    if (prod[PW-1]) begin
      frac  = prod[PW-2:0];
      exp_n = exp_sum + SW'(1);
    end else begin
      frac  = {prod[PW-3:0], 1'b0};
      exp_n = exp_sum;
    end

    // Zero padding keeps the slices legal even when the output mantissa
    // is wider than the fraction the product provides.
    grid     = {frac, {(OUT_POINT + 2){1'b0}}};
    mant     = grid[GW-1 -: OUT_POINT];
    guard    = grid[GW-1-OUT_POINT];
    sticky   = |grid[GW-2-OUT_POINT:0];
    inc      = (ROUND == ROUND_RNE) && guard && (sticky || mant[0]);
    mant_inc = {1'b0, mant} + MW'(inc);
    exp_r    = mant_inc[OUT_POINT] ? exp_n + SW'(1) : exp_n;
    eb       = exp_r + SW'(OUT_BIAS);

    result = '0;
    of     = 1'b0;
    uf     = 1'b0;
    if (!zero) begin
      if (eb > EB_MAX) begin
        result = '1;
        of     = 1'b1;
      end else if (eb[SW-1]) begin
        uf = 1'b1;
      end else begin
        result = {eb[EWO-1:0], mant_inc[OUT_POINT-1:0]};
        uf     = ~|{eb[EWO-1:0], mant_inc[OUT_POINT-1:0]};
      end
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined multiplier for unsigned custom floats with independent
// operand/result formats: unpack + exponent sum, mantissa product, normalise/round.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int N         = 12,
  parameter int IN1_POINT = 8,
  parameter int IN2_POINT = 8,
  parameter int OUT_POINT = 8,
  parameter int IN1_BIAS  = 7,
  parameter int IN2_BIAS  = 7,
  parameter int OUT_BIAS  = 7,
  parameter int ROUND     = ROUND_RNE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         of_flag,
  output logic         uf_flag
);

  localparam int E1 = expw(N, IN1_POINT);
  localparam int E2 = expw(N, IN2_POINT);
  localparam int EO = expw(N, OUT_POINT);
  localparam int SW = sumw(E1, E2, EO);
  localparam int PW = prodw(IN1_POINT, IN2_POINT);

  // Handshake: a transfer happens on any cycle where valid and ready are both 1.
  // The whole pipe advances as one when the output slot is empty or being taken,
  // so in_ready is exactly that advance condition and every stage holds otherwise.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic                 s1_valid;
  logic [IN1_POINT:0]   s1_m1;
  logic [IN2_POINT:0]   s1_m2;
  logic signed [SW-1:0] s1_exp;
  logic                 s1_zero;

  logic                 s2_valid;
  logic [PW-1:0]        s2_prod;
  logic signed [SW-1:0] s2_exp;
  logic                 s2_zero;

  logic signed [SW-1:0] exp_in;
  logic [N-1:0]         nr_result;
  logic                 nr_of;
  logic                 nr_uf;

  always_comb begin
    exp_in = $signed(SW'(in1[N-1:IN1_POINT])) - SW'(IN1_BIAS)
           + $signed(SW'(in2[N-1:IN2_POINT])) - SW'(IN2_BIAS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_m1    <= '0;
      s1_m2    <= '0;
      s1_exp   <= '0;
      s1_zero  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_m1    <= {1'b1, in1[IN1_POINT-1:0]};
      s1_m2    <= {1'b1, in2[IN2_POINT-1:0]};
      s1_exp   <= exp_in;
      s1_zero  <= (in1 == '0) || (in2 == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_exp   <= '0;
      s2_zero  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_prod  <= PW'(s1_m1) * PW'(s1_m2);
      s2_exp   <= s1_exp;
      s2_zero  <= s1_zero;
    end
  end

  fp_norm_round #(
    .PW        (PW),
    .SW        (SW),
    .N         (N),
    .OUT_POINT (OUT_POINT),
    .OUT_BIAS  (OUT_BIAS),
    .ROUND     (ROUND)
  ) u_norm_round (
    .prod    (s2_prod),
    .exp_sum (s2_exp),
    .zero    (s2_zero),
    .result  (nr_result),
    .of      (nr_of),
    .uf      (nr_uf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      of_flag   <= 1'b0;
      uf_flag   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out       <= nr_result;
      of_flag   <= nr_of;
      uf_flag   <= nr_uf;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: a round-to-nearest-even instance and a truncating
// instance share the same stimulus; hand-computed results are checked with assertions.
module tb_fp_mult_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] in1;
  logic [11:0] in2;

  logic        in_ready,  out_valid,  of_flag,  uf_flag;
  logic [11:0] out;
  logic        in_ready_t, out_valid_t, of_flag_t, uf_flag_t;
  logic [11:0] out_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];

  fp_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .of_flag   (of_flag),
    .uf_flag   (uf_flag)
  );

  fp_mult_pipe #(.ROUND(0)) dut_t (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_t),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid_t),
    .out_ready (out_ready),
    .out       (out_t),
    .of_flag   (of_flag_t),
    .uf_flag   (uf_flag_t)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operand pair with out_ready held high; result must appear exactly 3 edges later.
  task automatic run_one(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] exp_rne, input logic [11:0] exp_trunc,
                         input logic exp_of, input logic exp_uf);
    in1 = a;
    in2 = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    tick();
    check({tag, "_lat2"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, out, exp_rne);
    check({tag, "_of"}, of_flag, exp_of);
    check({tag, "_uf"}, uf_flag, exp_uf);
    check({tag, "_trunc_out"}, out_t, exp_trunc);
  endtask

  initial begin
    logic [11:0] va [6];
    logic [11:0] vb [6];
    logic [11:0] vr [6];
    logic [11:0] held;
    logic [11:0] exp_v;
    logic        have_held;
    int          sent;
    int          got;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_of", of_flag, 0);
    check("reset_uf", uf_flag, 0);
    check("reset_in_ready", in_ready, 1);

    // main function, rounding, zero and range boundaries
    run_one("one_x_one",   12'h700, 12'h700, 12'h700, 12'h700, 1'b0, 1'b0);
    run_one("1p5_sq",      12'h780, 12'h780, 12'h820, 12'h820, 1'b0, 1'b0);
    run_one("zero_op",     12'h000, 12'h780, 12'h000, 12'h000, 1'b0, 1'b0);
    run_one("zero_vs_big", 12'hFFF, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);
    run_one("tie_even",    12'h701, 12'h780, 12'h782, 12'h781, 1'b0, 1'b0);
    run_one("rnd_carry",   12'h780, 12'h755, 12'h800, 12'h7FF, 1'b0, 1'b0);
    run_one("below_half",  12'h7FF, 12'h7FF, 12'h8FE, 12'h8FE, 1'b0, 1'b0);
    run_one("overflow",    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b0);
    run_one("max_exp",     12'hB00, 12'hB00, 12'hF00, 12'hF00, 1'b0, 1'b0);
    run_one("underflow",   12'h100, 12'h100, 12'h000, 12'h000, 1'b0, 1'b1);
    run_one("zero_encode", 12'h400, 12'h300, 12'h000, 12'h000, 1'b0, 1'b1);

    // streaming with a 4-cycle consumer stall
    va[0] = 12'h700; vb[0] = 12'h700; vr[0] = 12'h700;
    va[1] = 12'h780; vb[1] = 12'h780; vr[1] = 12'h820;
    va[2] = 12'h701; vb[2] = 12'h780; vr[2] = 12'h782;
    va[3] = 12'hFFF; vb[3] = 12'hFFF; vr[3] = 12'hFFF;
    va[4] = 12'h100; vb[4] = 12'h100; vr[4] = 12'h000;
    va[5] = 12'h780; vb[5] = 12'h755; vr[5] = 12'h800;
    sent = 0;
    got = 0;
    have_held = 1'b0;
    held = '0;
    tick();
    for (int c = 0; c < 60 && got < 6; c++) begin
      out_ready = !(c >= 3 && c < 7);
      if (sent < 6) begin
        in_valid = 1'b1;
        in1 = va[sent];
        in2 = vb[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (have_held) check("stall_hold", out, held);
        else begin
          held = out;
          have_held = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        check("stream_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("stream_out", out, exp_v);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(vr[sent]);
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got, 6);
    check("stream_sent", sent, 6);
    check("stall_seen", have_held, 1);
    for (int i = 0; i < 4; i++) begin
      check("stream_no_dup", out_valid, 0);
      tick();
    end

    // reset with results in flight
    in_valid = 1'b1;
    in1 = 12'h780; in2 = 12'h780;
    tick();
    in1 = 12'h700; in2 = 12'h700;
    tick();
    in1 = 12'hFFF; in2 = 12'hFFF;
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_out", out, 12'h820);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_out", out, 0);
    check("rst_async_of", of_flag, 0);
    check("rst_async_uf", uf_flag, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_idle", out_valid, 0);
    end
    run_one("post_rst", 12'h780, 12'h780, 12'h820, 12'h820, 1'b0, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
